// File: rtl/fas_frame_sched.sv
// rtl/fas_frame_sched.sv - ping-pong frame scheduler feeding the 16-point FFT engine.
// Optional macro FAS_SCHED_DROPCNT_EN adds a saturating drop_cnt output.
module fas_frame_sched #(
   parameter int DW         = 16,
   parameter int N          = 16,
   parameter int NUM_FRAMES = 64,
   localparam int AW        = $clog2(N),
   localparam int FW        = $clog2(NUM_FRAMES)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          fir_valid,
   input  logic [DW-1:0] fir_d,
   output logic          fft_start,
   output logic          fft_bank,
   input  logic [AW-1:0] fft_rd_addr,
   output logic [DW-1:0] fft_rd_data,
   input  logic          fft_done,
   output logic [FW-1:0] frame_idx,
   output logic          all_done,
   output logic          ovf
`ifdef FAS_SCHED_DROPCNT_EN
   ,
   output logic [7:0]    drop_cnt
`endif
);

   typedef enum logic [1:0] {IDLE, START, BUSY, DONE} state_t;

   state_t        state_q, state_d;
   logic          wr_bank_q, wr_bank_d;
   logic          rd_bank_q, rd_bank_d;
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [1:0]    full_q, full_d;
   logic [FW-1:0] cnt_q, cnt_d;
   logic [FW-1:0] frame_idx_q, frame_idx_d;
   logic          fft_start_q, fft_start_d;
   logic          fft_bank_q, fft_bank_d;
   logic          all_done_q, all_done_d;
   logic          ovf_q, ovf_d;
   logic [DW-1:0] mem_q [2][N];

   logic          rel;
   logic          wr_ok;
   logic          wr_en;
   logic          drop;
   logic          wr_last;

   // A bank freed this cycle may be refilled in the same cycle.
   always_comb begin
      rel     = (state_q == BUSY) && fft_done;
      wr_ok   = !full_q[wr_bank_q] || (rel && (rd_bank_q == wr_bank_q));
      wr_en   = fir_valid && wr_ok && (state_q != DONE);
      drop    = fir_valid && !wr_ok && (state_q != DONE);
      wr_last = (wr_ptr_q == AW'(N - 1));
   end

   always_comb begin
      full_d    = full_q;
      wr_ptr_d  = wr_ptr_q;
      wr_bank_d = wr_bank_q;
      ovf_d     = ovf_q | drop;
      if (rel) begin
         full_d[rd_bank_q] = 1'b0;
      end
      if (wr_en) begin
         wr_ptr_d = wr_ptr_q + AW'(1);
         if (wr_last) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
         end
      end
   end

   always_comb begin
      state_d     = state_q;
      rd_bank_d   = rd_bank_q;
      cnt_d       = cnt_q;
      fft_start_d = 1'b0;
      fft_bank_d  = fft_bank_q;
      frame_idx_d = frame_idx_q;
      all_done_d  = all_done_q;
      case (state_q)
         IDLE: begin
            if (full_q[rd_bank_q]) begin
               state_d     = START;
               fft_start_d = 1'b1;
               fft_bank_d  = rd_bank_q;
               frame_idx_d = cnt_q;
            end
         end
         START: state_d = BUSY;
         BUSY: begin
            if (fft_done) begin
               rd_bank_d = ~rd_bank_q;
               cnt_d     = cnt_q + FW'(1);
               if (cnt_q == FW'(NUM_FRAMES - 1)) begin
                  state_d    = DONE;
                  all_done_d = 1'b1;
               end else begin
                  state_d = IDLE;
               end
            end
         end
         DONE:    state_d = DONE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= IDLE;
         wr_bank_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         wr_ptr_q    <= '0;
         full_q      <= '0;
         cnt_q       <= '0;
         frame_idx_q <= '0;
         fft_start_q <= 1'b0;
         fft_bank_q  <= 1'b0;
         all_done_q  <= 1'b0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_bank_q   <= wr_bank_d;
         rd_bank_q   <= rd_bank_d;
         wr_ptr_q    <= wr_ptr_d;
         full_q      <= full_d;
         cnt_q       <= cnt_d;
         frame_idx_q <= frame_idx_d;
         fft_start_q <= fft_start_d;
         fft_bank_q  <= fft_bank_d;
         all_done_q  <= all_done_d;
         ovf_q       <= ovf_d;
      end
   end

   // Sample storage carries no reset; contents are only meaningful once a bank is full.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         mem_q[wr_bank_q][wr_ptr_q] <= fir_d;
      end
   end

`ifdef FAS_SCHED_DROPCNT_EN
   logic [7:0] drop_cnt_q, drop_cnt_d;

   always_comb begin
      drop_cnt_d = drop_cnt_q;
      if (drop && (drop_cnt_q != 8'hFF)) begin
         drop_cnt_d = drop_cnt_q + 8'd1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         drop_cnt_q <= 8'd0;
      end else begin
         drop_cnt_q <= drop_cnt_d;
      end
   end

   assign drop_cnt = drop_cnt_q;
`endif

   assign fft_start   = fft_start_q;
   assign fft_bank    = fft_bank_q;
   assign frame_idx   = frame_idx_q;
   assign all_done    = all_done_q;
   assign ovf         = ovf_q;
   assign fft_rd_data = mem_q[fft_bank_q][fft_rd_addr];

endmodule

// File: tb/tb_fas_frame_sched.sv
// tb/tb_fas_frame_sched.sv - directed scoreboard bench for fas_frame_sched.
// Honours FAS_SCHED_DROPCNT_EN when the design is built with it.
module tb_fas_frame_sched;
   localparam int DW = 16;
   localparam int N  = 16;
   localparam int NF = 64;

   logic          clk = 1'b0;
   logic          rst = 1'b0;
   logic          fir_valid = 1'b0;
   logic [DW-1:0] fir_d = '0;
   logic          fft_done = 1'b0;
   logic [3:0]    fft_rd_addr = '0;
   logic          fft_start;
   logic          fft_bank;
   logic [DW-1:0] fft_rd_data;
   logic [5:0]    frame_idx;
   logic          all_done;
   logic          ovf;
`ifdef FAS_SCHED_DROPCNT_EN
   logic [7:0]    drop_cnt;
`endif

   fas_frame_sched #(.DW(DW), .N(N), .NUM_FRAMES(NF)) dut (
      .clk         (clk),
      .rst         (rst),
      .fir_valid   (fir_valid),
      .fir_d       (fir_d),
      .fft_start   (fft_start),
      .fft_bank    (fft_bank),
      .fft_rd_addr (fft_rd_addr),
      .fft_rd_data (fft_rd_data),
      .fft_done    (fft_done),
      .frame_idx   (frame_idx),
      .all_done    (all_done),
      .ovf         (ovf)
`ifdef FAS_SCHED_DROPCNT_EN
      ,
      .drop_cnt    (drop_cnt)
`endif
   );

   always #20 clk = ~clk;

   int            checks = 0;
   int            errors = 0;
   logic [DW-1:0] exp_q[$];
   int            exp_start_n = 0;
   int            auto_dly = 0;
   int            done_limit = 1000;
   int            timer = 0;
   int            dones = 0;
   bit            last_dn = 1'b0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, "_fft_start"}, fft_start, 0);
      chk({tag, "_fft_bank"},  fft_bank,  0);
      chk({tag, "_frame_idx"}, frame_idx, 0);
      chk({tag, "_all_done"},  all_done,  0);
      chk({tag, "_ovf"},       ovf,       0);
`ifdef FAS_SCHED_DROPCNT_EN
      chk({tag, "_drop_cnt"},  drop_cnt,  0);
`endif
   endtask

   task automatic clear_model();
      exp_q.delete();
      exp_start_n = 0;
      timer       = 0;
      dones       = 0;
   endtask

   task automatic do_reset(input string tag);
      @(posedge clk);
      #1 rst = 1'b0;
      #1 chk_zero(tag);
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b1;
      clear_model();
   endtask

   // One clock: drive, take the edge, then on any fft_start check bank, index and frame contents.
   task automatic tick(input bit v, input logic [DW-1:0] d, input bit dn, input bit push);
      bit dn_eff;
      dn_eff = dn || (timer == 1);
      if (timer > 0) timer--;
      fir_valid = v;
      fir_d     = d;
      fft_done  = dn_eff;
      if (v && push) exp_q.push_back(d);
      @(posedge clk);
      #1;
      fir_valid = 1'b0;
      fft_done  = 1'b0;
      last_dn   = dn_eff;
      if (dn_eff) dones++;
      if (fft_start) begin
         chk("start_bank", fft_bank, exp_start_n % 2);
         chk("start_idx", frame_idx, exp_start_n);
         if (exp_q.size() < N) begin
            chk("sb_underflow", exp_q.size(), N);
         end else begin
            for (int a = 0; a < N; a++) begin
               fft_rd_addr = 4'(a);
               #1 chk("rd_data", fft_rd_data, exp_q.pop_front());
            end
         end
         exp_start_n++;
         if (auto_dly > 0 && exp_start_n <= done_limit) timer = auto_dly;
      end
   endtask

   initial begin
      // Single frame: start latency, bank 0, readback of 0x0001..0x0010.
      do_reset("reset");
      for (int i = 0; i < 16; i++) tick(1'b1, 16'(i + 1), 1'b0, 1'b1);
      chk("start_early", fft_start, 0);
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("start_latency", fft_start, 1);
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("start_pulse", fft_start, 0);
      repeat (17) tick(1'b0, '0, 1'b0, 1'b0);
      chk("bank_stable", fft_bank, 0);
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("t1_ovf", ovf, 0);
      chk("t1_starts", exp_start_n, 1);

      // fft_done in IDLE with nothing full must not advance the frame counter.
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("idle_done_idx", frame_idx, 0);
      repeat (2) tick(1'b0, '0, 1'b0, 1'b0);
      chk("idle_done_nostart", exp_start_n, 1);
      for (int i = 0; i < 16; i++) tick(1'b1, 16'(i + 17), 1'b0, 1'b1);
      repeat (3) tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      chk("t5_starts", exp_start_n, 2);

      // Full run of 1024 samples with fft_done 5 cycles after each start.
      do_reset("reset2");
      auto_dly = 5;
      for (int i = 0; i < 1024 + 20; i++) begin
         tick(i < 1024, 16'(i + 1), 1'b0, 1'b1);
         if (last_dn) begin
            if (dones == NF) chk("all_done_rise", all_done, 1);
            else             chk("all_done_early", all_done, 0);
         end
      end
      chk("run_starts", exp_start_n, NF);
      chk("run_ovf", ovf, 0);
      chk("run_last_idx", frame_idx, NF - 1);
      auto_dly = 0;
      for (int i = 0; i < 20; i++) tick(1'b1, 16'hAAAA, 1'b1, 1'b0);
      chk("done_hold", all_done, 1);
      chk("done_no_ovf", ovf, 0);
      chk("done_no_start", exp_start_n, NF);
      chk("done_idx", frame_idx, NF - 1);
`ifdef FAS_SCHED_DROPCNT_EN
      chk("done_drop_cnt", drop_cnt, 0);
`endif

      // Withheld fft_done: samples 33..40 are dropped.
      do_reset("reset3");
      for (int i = 0; i < 40; i++) begin
         tick(1'b1, 16'(i + 1), 1'b0, i < 32);
         if (i == 31) chk("ovf_before", ovf, 0);
      end
      chk("ovf_after", ovf, 1);
`ifdef FAS_SCHED_DROPCNT_EN
      chk("drop_cnt", drop_cnt, 8);
`endif
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("ovf_bank1_start", fft_start, 1);
      chk("ovf_starts", exp_start_n, 2);

      // Release coinciding with a fill of the other bank, and with a write to the freed bank.
      do_reset("reset4");
      for (int i = 0; i < 31; i++) tick(1'b1, 16'(i + 1), 1'b0, 1'b1);
      tick(1'b1, 16'd32, 1'b1, 1'b1);
      tick(1'b1, 16'd33, 1'b0, 1'b1);
      chk("b2b_start", fft_start, 1);
      for (int i = 34; i <= 48; i++) tick(1'b1, 16'(i), 1'b0, 1'b1);
      tick(1'b1, 16'd49, 1'b1, 1'b1);
      chk("same_cycle_ovf", ovf, 0);
      tick(1'b1, 16'd50, 1'b0, 1'b1);
      chk("after_rel_start", fft_start, 1);
      for (int i = 51; i <= 64; i++) tick(1'b1, 16'(i), 1'b0, 1'b1);
      tick(1'b0, '0, 1'b0, 1'b0);
      tick(1'b0, '0, 1'b1, 1'b0);
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("refill_start", fft_start, 1);
      chk("t4_starts", exp_start_n, 4);
      chk("t4_ovf", ovf, 0);

      // Reset while frame 5 is in BUSY and 7 samples are in the write bank.
      do_reset("reset5");
      auto_dly   = 5;
      done_limit = 5;
      for (int i = 0; i < 103; i++) tick(1'b1, 16'(i + 1), 1'b0, 1'b1);
      chk("mid_starts", exp_start_n, 6);
      chk("mid_idx", frame_idx, 5);
      rst = 1'b0;
      #1 chk_zero("async_reset");
      @(posedge clk);
      #1 rst = 1'b1;
      clear_model();
      auto_dly   = 0;
      done_limit = 1000;
      for (int i = 0; i < 16; i++) tick(1'b1, 16'(16'h0100 + i), 1'b0, 1'b1);
      chk("post_reset_nostart", exp_start_n, 0);
      tick(1'b0, '0, 1'b0, 1'b0);
      chk("post_reset_start", fft_start, 1);
      chk("post_reset_starts", exp_start_n, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fas_frame_sched.md
Name: fas_frame_sched

Overview:
Frame scheduler between the FIR output stream and the 16-point FFT engine in the FAS datapath. It captures FIR samples into two 16-entry ping-pong banks and starts the FFT on each full bank. It holds the bank until the FFT engine reports done, then counts frames and flags end-of-run after NUM_FRAMES frames. It also serves the FFT engine's zero-latency sample reads from the bank under transform.

Parameters:
DW, 16, sample width (FIR format: 8 integer + 8 fraction)
N, 16, frame length; power of two; address width AW = log2(N)
NUM_FRAMES, 64, frames per run (1024 samples / 16)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  asynchronous, active-low reset
fir_valid  in  1  fir_d valid this cycle
fir_d  in  DW  FIR sample
fft_start  out  1  one-cycle pulse: start a transform on bank fft_bank
fft_bank  out  1  bank under transform; stable from fft_start until release
fft_rd_addr  in  AW  FFT engine sample read address
fft_rd_data  out  DW  buf[fft_bank][fft_rd_addr]; combinational, 0 latency
fft_done  in  1  one-cycle pulse from the FFT engine: transform finished, bank may be released
frame_idx  out  log2(NUM_FRAMES)  index of the frame currently or last started
all_done  out  1  high once NUM_FRAMES frames are released; held until reset
ovf  out  1  sticky: a sample was dropped because its target bank was full

Behaviour:
- Reset (rst=0, asynchronous): FSM=IDLE, wr_bank=0, rd_bank=0, wr_ptr=0, full[1:0]=0, frame counter=0. All outputs 0: fft_start, fft_bank, frame_idx, all_done, ovf. fft_rd_data reflects bank 0. Buffer contents are don't-care.
- Write side: a write is permitted when full[wr_bank]=0, or when a release of the same bank happens in the same cycle.
  - On fir_valid with write permitted: buf[wr_bank][wr_ptr] <= fir_d, then wr_ptr++.
  - If wr_ptr was N-1: full[wr_bank] <= 1, wr_bank toggles, wr_ptr wraps to 0.
- Drop: fir_valid with write not permitted -> sample discarded, wr_ptr unchanged, ovf <= 1.
- FSM states: IDLE, START, BUSY, DONE.
  - IDLE: if full[rd_bank]=1 -> START.
  - START: fft_start=1 for exactly one cycle; fft_bank<=rd_bank; frame_idx<=frame counter -> BUSY.
  - BUSY: wait for fft_done. On fft_done: full[rd_bank]<=0, rd_bank toggles, frame counter++. If the counter was NUM_FRAMES-1 -> DONE, else -> IDLE.
  - DONE: all_done=1. All further fir_valid samples are discarded without setting ovf. fft_done is ignored. The state exits only on reset.
- fft_done is ignored in IDLE and START (no state change, no release).
- Latency: the sample-N capture edge E sets full. Edge E+1 enters START, so fft_start is high from E+1 to E+2.
- Back-to-back: if the other bank is already full at release, IDLE goes to START on the next edge. Release to next fft_start is 2 cycles.
- A release and a completed fill of the other bank in the same cycle both take effect.
- fft_rd_data is valid for any address at any time. Its content is defined only between fft_start and release.
- Reset mid-frame or mid-transform: a partial frame is discarded and the engine sees no further fft_start. The FFT engine is reset by the same rst.

Optional Feature:
Macro FAS_SCHED_DROPCNT_EN.
- Defined: adds output drop_cnt [7:0]. It increments on every ovf-type drop, saturates at 255, and is reset to 0. DONE-state discards are not counted.
- Undefined: the port and counter are absent; only the sticky ovf exists.

Test Plan:
- Continuous fir_valid, samples 0x0001..0x0010, fft_done returned 20 cycles after each fft_start -> fft_start 2 cycles after the 16th sample, fft_bank=0. Reads at addr 0..15 return 0x0001..0x0010. No ovf.
- 1024 continuous samples, fft_done 5 cycles after each fft_start -> 64 fft_start pulses, fft_bank alternating 0/1, frame_idx 0..63. all_done rises on the cycle after the 64th fft_done. ovf=0.
- Withhold fft_done until 40 samples are sent -> samples 33..40 dropped, ovf=1. After fft_done, the next frame in bank 1 holds samples 17..32. (DROPCNT_EN: drop_cnt=8.)
- Release and the last write into the freed bank in the same cycle -> the sample is stored, no ovf, full[bank]=1 afterwards.
- fft_done pulse in IDLE with no full bank -> no state change, frame_idx unchanged. fft_done asserted during DONE -> ignored.
- rst low for 1 cycle while in BUSY at frame 5 with wr_ptr=7 -> all outputs 0 immediately. The next 16 samples form frame 0 in bank 0.
